// File: rtl/fcta_bram_rd_arbiter_if.sv
// Client/BRAM-side bundle of the FCTA BRAM read arbiter.
// The slave modport is the arbiter; master is the clients plus the BRAM.
interface fcta_bram_rd_arbiter_if #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 16,
    parameter int unsigned CNT_W = 16
);
    logic             hold;
    logic             r0_req;
    logic [AW-1:0]    r0_addr;
    logic             r0_gnt;
    logic             r1_req;
    logic [AW-1:0]    r1_addr;
    logic             r1_gnt;
    logic             rsp_valid;
    logic             rsp_id;
    logic [DW-1:0]    rsp_data;
    logic             wr_req;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             bram_wea;
    logic [AW-1:0]    bram_addra;
    logic [DW-1:0]    bram_dina;
    logic             bram_enb;
    logic [AW-1:0]    bram_addrb;
    logic             bram_regceb;
    logic             bram_rstb;
    logic [DW-1:0]    bram_doutb;
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    modport master (
        output hold, r0_req, r0_addr, r1_req, r1_addr, wr_req, wr_addr, wr_data, bram_doutb,
        input  r0_gnt, r1_gnt, rsp_valid, rsp_id, rsp_data,
               bram_wea, bram_addra, bram_dina, bram_enb, bram_addrb, bram_regceb, bram_rstb,
               gnt_cnt0, gnt_cnt1
    );

    modport slave (
        input  hold, r0_req, r0_addr, r1_req, r1_addr, wr_req, wr_addr, wr_data, bram_doutb,
        output r0_gnt, r1_gnt, rsp_valid, rsp_id, rsp_data,
               bram_wea, bram_addra, bram_dina, bram_enb, bram_addrb, bram_regceb, bram_rstb,
               gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/fcta_bram_rd_arbiter.sv
// Round-robin share of the BRAM_SDP_1C read port between two requesters,
// with latency-matched response tagging, write pass-through and grant counters.
module fcta_bram_rd_arbiter #(
    parameter int unsigned RAM_WIDTH  = 16,
    parameter int unsigned RAM_DEPTH  = 1024,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                   clka,
    input  logic                   rstb,
    fcta_bram_rd_arbiter_if.slave  bus
);
    localparam int unsigned AW = $clog2(RAM_DEPTH);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("fcta_bram_rd_arbiter: RD_LATENCY must be 1 or 2");
    end

    // rr_ptr holds the ID that wins the next contended cycle (0 after reset)
    logic             rr_ptr;
    logic             r0_gnt_c;
    logic             r1_gnt_c;
    logic             gnt_any_c;
    logic [AW-1:0]    gnt_addr_c;
    logic [AW-1:0]    addrb_q;
    logic             s1_vld, s1_id;
    logic             s2_vld, s2_id;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    always_comb begin
        r0_gnt_c = 1'b0;
        r1_gnt_c = 1'b0;
        if (!rstb && !bus.hold) begin
            if (bus.r0_req && (!bus.r1_req || !rr_ptr)) begin
                r0_gnt_c = 1'b1;
            end else if (bus.r1_req) begin
                r1_gnt_c = 1'b1;
            end
        end
    end

    assign gnt_any_c  = r0_gnt_c | r1_gnt_c;
    assign gnt_addr_c = r0_gnt_c ? bus.r0_addr : bus.r1_addr;

    always_ff @(posedge clka) begin
        if (rstb) begin
            rr_ptr <= 1'b0;
            s1_vld <= 1'b0;
            s1_id  <= 1'b0;
            s2_vld <= 1'b0;
            s2_id  <= 1'b0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (r0_gnt_c) begin
                rr_ptr <= 1'b1;
            end else if (r1_gnt_c) begin
                rr_ptr <= 1'b0;
            end
            s1_vld <= gnt_any_c;
            s1_id  <= r1_gnt_c;
            s2_vld <= s1_vld;
            s2_id  <= s1_id;
            if (r0_gnt_c && cnt0_q != '1) cnt0_q <= cnt0_q + CNT_W'(1);
            if (r1_gnt_c && cnt1_q != '1) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    // Read address is left unreset: it only matters while enb is high
    always_ff @(posedge clka) begin
        if (gnt_any_c) addrb_q <= gnt_addr_c;
    end

    always_comb begin
        bus.r0_gnt      = r0_gnt_c;
        bus.r1_gnt      = r1_gnt_c;
        bus.bram_enb    = gnt_any_c;
        bus.bram_addrb  = gnt_any_c ? gnt_addr_c : addrb_q;
        bus.bram_regceb = (RD_LATENCY == 2) ? s1_vld : 1'b0;
        bus.bram_rstb   = rstb;
        bus.rsp_valid   = (RD_LATENCY == 2) ? s2_vld : s1_vld;
        bus.rsp_id      = (RD_LATENCY == 2) ? s2_id  : s1_id;
        bus.rsp_data    = RAM_WIDTH'(bus.bram_doutb);
        bus.gnt_cnt0    = cnt0_q;
        bus.gnt_cnt1    = cnt1_q;
    end

    // Write stream goes straight to port A; the BRAM resolves collisions read-first
    always_comb begin
        bus.bram_wea   = bus.wr_req & ~rstb;
        bus.bram_addra = bus.wr_addr;
        bus.bram_dina  = bus.wr_data;
    end
endmodule
